// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the 4-state (K=3) Viterbi decoder blocks.
package viterbi_pkg;

    localparam int NUM_STATES = 4;

    typedef logic [1:0] tstate_t;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        TRACE  = 2'd1,
        OUTPUT = 2'd2
    } tbu_fsm_e;

    // Predecessor of state s, given the ACSU decision bit for s.
    function automatic tstate_t pred_state(input tstate_t s, input logic dec);
        return {s[0], dec};
    endfunction

endpackage

// File: rtl/pm_argmin.sv
// Combinational index of the smallest of four path metrics; ties go to the lowest index.
module pm_argmin
    import viterbi_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [PM_W-1:0] pm2_i,
    input  logic [PM_W-1:0] pm3_i,
    output tstate_t         idx_o
);

    logic            sel01;
    logic            sel23;
    logic [PM_W-1:0] min01;
    logic [PM_W-1:0] min23;

    // Strict less-than keeps the lower index on a tie at every level.
    assign sel01 = (pm1_i < pm0_i);
    assign sel23 = (pm3_i < pm2_i);
    assign min01 = sel01 ? pm1_i : pm0_i;
    assign min23 = sel23 ? pm3_i : pm2_i;
    assign idx_o = (min23 < min01) ? {1'b1, sel23} : {1'b0, sel01};

endmodule

// File: rtl/tbu_frame.sv
// Frame-based traceback unit: stores FRAME_LEN decision words, traces back from the
// best-metric state, then streams the decoded bits oldest-first.
module tbu_frame
    import viterbi_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int PM_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [NUM_STATES-1:0] dec_bits_i,
    input  logic [PM_W-1:0]       pm_s0_i,
    input  logic [PM_W-1:0]       pm_s1_i,
    input  logic [PM_W-1:0]       pm_s2_i,
    input  logic [PM_W-1:0]       pm_s3_i,
    output logic                  bit_o,
    output logic                  bit_valid_o,
    input  logic                  out_ready_i,
    output logic                  frame_last_o
);

    localparam int               PTR_W = $clog2(FRAME_LEN);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(FRAME_LEN - 1);

    tbu_fsm_e         fsm_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] idx_q;
    tstate_t          state_q;
    tstate_t          start_state_q;
    logic             bit_q;
    logic             bit_valid_q;
    logic             frame_last_q;

    logic [NUM_STATES-1:0] mem  [FRAME_LEN];
    logic                  obuf [FRAME_LEN];

    logic                  accept;
    tstate_t               argmin_idx;
    tstate_t               trace_state;
    logic [NUM_STATES-1:0] dec_row;
    logic [PTR_W-1:0]      rd_ptr_d;

    assign ready_o     = (fsm_q == FILL) && !rst_i;
    assign accept      = valid_i && ready_o;
    // The first traceback step starts from the captured best state.
    assign trace_state = (idx_q == LAST) ? start_state_q : state_q;
    assign dec_row     = mem[idx_q];
    assign rd_ptr_d    = rd_ptr_q + PTR_W'(1);

    assign bit_o        = bit_q;
    assign bit_valid_o  = bit_valid_q;
    assign frame_last_o = frame_last_q;

    pm_argmin #(.PM_W(PM_W)) u_argmin (
        .pm0_i (pm_s0_i),
        .pm1_i (pm_s1_i),
        .pm2_i (pm_s2_i),
        .pm3_i (pm_s3_i),
        .idx_o (argmin_idx)
    );

    // Storage arrays carry no reset; a restarted frame overwrites them before use.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem[wr_ptr_q] <= dec_bits_i;
        end
        if (fsm_q == TRACE) begin
            obuf[idx_q] <= trace_state[1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q         <= FILL;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            idx_q         <= '0;
            state_q       <= '0;
            start_state_q <= '0;
            bit_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_last_q  <= 1'b0;
        end else begin
            case (fsm_q)
                FILL: begin
                    if (accept) begin
                        if (wr_ptr_q == LAST) begin
                            wr_ptr_q      <= '0;
                            start_state_q <= argmin_idx;
                            idx_q         <= LAST;
                            fsm_q         <= TRACE;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
                TRACE: begin
                    state_q <= pred_state(trace_state, dec_row[trace_state]);
                    if (idx_q == '0) begin
                        fsm_q <= OUTPUT;
                    end else begin
                        idx_q <= idx_q - PTR_W'(1);
                    end
                end
                OUTPUT: begin
                    // First OUTPUT cycle only loads bit 0, since obuf[0] lands on the last TRACE edge.
                    if (!bit_valid_q) begin
                        bit_q        <= obuf[rd_ptr_q];
                        frame_last_q <= (rd_ptr_q == LAST);
                        bit_valid_q  <= 1'b1;
                    end else if (out_ready_i) begin
                        if (rd_ptr_q == LAST) begin
                            fsm_q        <= FILL;
                            rd_ptr_q     <= '0;
                            bit_q        <= 1'b0;
                            bit_valid_q  <= 1'b0;
                            frame_last_q <= 1'b0;
                        end else begin
                            rd_ptr_q     <= rd_ptr_d;
                            bit_q        <= obuf[rd_ptr_d];
                            frame_last_q <= (rd_ptr_d == LAST);
                        end
                    end
                end
                default: fsm_q <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_tbu_frame.sv
// Randomized bench for tbu_frame: a trellis traceback model predicts each frame's bits.
module tb_tbu_frame;

    localparam int FL   = 16;
    localparam int PM_W = 8;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [3:0]      dec_bits_i;
    logic [PM_W-1:0] pm_s0_i, pm_s1_i, pm_s2_i, pm_s3_i;
    logic            bit_o;
    logic            bit_valid_o;
    logic            out_ready_i;
    logic            frame_last_o;

    int errors = 0;
    int checks = 0;
    int frame_no = 0;
    bit noise = 1'b0;

    int unsigned step_dec [FL];
    int unsigned last_pm  [4];
    int unsigned exp_bits [FL];
    int unsigned exp_start;

    tbu_frame #(.FRAME_LEN(FL), .PM_W(PM_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .dec_bits_i   (dec_bits_i),
        .pm_s0_i      (pm_s0_i),
        .pm_s1_i      (pm_s1_i),
        .pm_s2_i      (pm_s2_i),
        .pm_s3_i      (pm_s3_i),
        .bit_o        (bit_o),
        .bit_valid_o  (bit_valid_o),
        .out_ready_i  (out_ready_i),
        .frame_last_o (frame_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (frame %0d, t=%0t)", tag, got, exp, frame_no, $time);
        end
    endtask

    task automatic rand_pms();
        pm_s0_i = PM_W'($urandom);
        pm_s1_i = PM_W'($urandom);
        pm_s2_i = PM_W'($urandom);
        pm_s3_i = PM_W'($urandom);
    endtask

    // One clock; with noise enabled, throw random steps at the block while it is busy.
    task automatic tick();
        if (noise) begin
            valid_i    = 1'($urandom_range(0, 1));
            dec_bits_i = 4'($urandom);
            rand_pms();
        end else begin
            valid_i = 1'b0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // Trellis reference: start at the best final metric, walk predecessors backwards.
    task automatic model_frame();
        int unsigned s;
        int unsigned best = 0;
        for (int k = 1; k < 4; k++) begin
            if (last_pm[k] < last_pm[best]) best = k;
        end
        exp_start = best;
        s = best;
        for (int t = FL - 1; t >= 0; t--) begin
            exp_bits[t] = s / 2;
            s = (s % 2) * 2 + ((step_dec[t] >> s) & 1);
        end
    endtask

    task automatic fill_frame(input int mode);
        for (int t = 0; t < FL; t++) begin
            case (mode)
                1, 2:    step_dec[t] = 0;
                3, 4:    step_dec[t] = 15;
                default: step_dec[t] = $urandom_range(0, 15);
            endcase
        end
        case (mode)
            1: last_pm = '{0, 10, 20, 30};
            2: last_pm = '{9, 9, 1, 9};
            3: last_pm = '{5, 5, 5, 0};
            4: last_pm = '{7, 7, 7, 7};
            default: for (int k = 0; k < 4; k++) last_pm[k] = $urandom_range(0, 15);
        endcase
        model_frame();
        for (int t = 0; t < FL; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_i    = 1'b0;
                dec_bits_i = 4'($urandom);
                @(posedge clk_i);
                @(negedge clk_i);
            end
            valid_i    = 1'b1;
            dec_bits_i = 4'(step_dec[t]);
            if (t == FL - 1) begin
                pm_s0_i = PM_W'(last_pm[0]);
                pm_s1_i = PM_W'(last_pm[1]);
                pm_s2_i = PM_W'(last_pm[2]);
                pm_s3_i = PM_W'(last_pm[3]);
            end else begin
                rand_pms();
            end
            check("fill_ready", ready_o, 1);
            @(posedge clk_i);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit noise_en, input int stall_at, input bit rand_stall);
        int k = 0;
        int nstall;
        frame_no++;
        out_ready_i = 1'b1;
        fill_frame(mode);
        noise = noise_en;
        // Now one half-cycle past the final accepting edge.
        while (!bit_valid_o && k < 40) begin
            check("busy_ready", ready_o, 0);
            tick();
            k++;
        end
        check("latency", k, FL + 1);
        for (int j = 0; j < FL; j++) begin
            check("bit_valid", bit_valid_o, 1);
            check("bit", bit_o, exp_bits[j]);
            check("frame_last", frame_last_o, (j == FL - 1) ? 1 : 0);
            nstall = (j == stall_at) ? 5 : (rand_stall ? $urandom_range(0, 2) : 0);
            for (int n = 0; n < nstall; n++) begin
                out_ready_i = 1'b0;
                tick();
                check("stall_valid", bit_valid_o, 1);
                check("stall_bit", bit_o, exp_bits[j]);
                check("stall_last", frame_last_o, (j == FL - 1) ? 1 : 0);
            end
            out_ready_i = 1'b1;
            tick();
        end
        noise = 1'b0;
        valid_i = 1'b0;
        check("valid_drop", bit_valid_o, 0);
        check("ready_back", ready_o, 1);
        $display("frame %0d mode=%0d start=S%0d noise=%0d stall_at=%0d first=%0d last=%0d errors=%0d",
                 frame_no, mode, exp_start, noise_en, stall_at, exp_bits[0], exp_bits[FL-1], errors);
    endtask

    task automatic reset_abort();
        bit seen = 1'b0;
        frame_no++;
        fill_frame(0);
        repeat (4) tick();
        rst_i = 1'b1;
        #1;
        check("async_rst_ready", ready_o, 0);
        check("async_rst_valid", bit_valid_o, 0);
        check("async_rst_last", frame_last_o, 0);
        check("async_rst_bit", bit_o, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("post_rst_ready", ready_o, 1);
        for (int n = 0; n < 30; n++) begin
            if (bit_valid_o) seen = 1'b1;
            tick();
        end
        check("abort_no_valid", seen, 0);
        $display("frame %0d aborted by reset in TRACE, bit_valid seen=%0d errors=%0d", frame_no, seen, errors);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        dec_bits_i  = '0;
        out_ready_i = 1'b1;
        rand_pms();
        @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ready", ready_o, 0);
        check("rst_valid", bit_valid_o, 0);
        check("rst_last", frame_last_o, 0);
        check("rst_bit", bit_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_ready", ready_o, 1);

        run_frame(1, 1'b0, -1, 1'b0);
        run_frame(2, 1'b0, -1, 1'b0);
        run_frame(3, 1'b0, -1, 1'b0);
        run_frame(4, 1'b0, -1, 1'b0);
        run_frame(0, 1'b0, 3, 1'b0);
        run_frame(0, 1'b1, -1, 1'b0);
        run_frame(0, 1'b1, 3, 1'b1);
        reset_abort();
        run_frame(0, 1'b0, -1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            run_frame(0, 1'($urandom_range(0, 1)), $urandom_range(0, FL - 1), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
